// File: rtl/decode_stage.sv
// Decode stage of the five-stage MIPS pipeline: F/D register, 32x32 register file
// with bypass/forwarding, immediate extension and branch/jump resolution in D.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    input  logic        D_en,
    input  logic        W_we,
    input  logic [4:0]  W_A3,
    input  logic [31:0] W_WD,
    input  logic        E_fwd_we,
    input  logic [4:0]  E_fwd_A,
    input  logic [31:0] E_fwd_D,
    input  logic        M_fwd_we,
    input  logic [4:0]  M_fwd_A,
    input  logic [31:0] M_fwd_D,
    output logic [31:0] NPC,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [31:0] D_RD1,
    output logic [31:0] D_RD2,
    output logic [31:0] D_Ext,
    output logic        D_br_taken
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_ADDU   = 6'b100001;
    localparam logic [5:0] FN_SUBU   = 6'b100011;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADDU, OP_SUBU, OP_ORI, OP_LUI, OP_LW,
        OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR
    } op_e;

    // ---------------- F/D pipeline register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            D_PC    <= RESET_PC;
            D_Instr <= '0;
        end else if (D_en) begin
            D_PC    <= F_PC;
            D_Instr <= F_Instr;
        end
    end

    // ---------------- General register file ----------------
    logic [31:0] grf [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this array is explicitly cleared on reset, so it maps to flops, not RAM.
            for (int i = 0; i < 32; i++) grf[i] <= '0;
        end else if (W_we && (W_A3 != 5'd0)) begin
            grf[W_A3] <= W_WD;
        end
    end

    // Youngest producer wins: E, then M, then the same-cycle W write, then the array.
    function automatic logic [31:0] select_operand(
        input logic [4:0]  idx,
        input logic [31:0] arr_val,
        input logic        e_we, input logic [4:0] e_a, input logic [31:0] e_d,
        input logic        m_we, input logic [4:0] m_a, input logic [31:0] m_d,
        input logic        w_we, input logic [4:0] w_a, input logic [31:0] w_d
    );
        if (idx == 5'd0)                 return 32'h0;
        else if (e_we && (e_a == idx))   return e_d;
        else if (m_we && (m_a == idx))   return m_d;
        else if (w_we && (w_a == idx))   return w_d;
        else                             return arr_val;
    endfunction

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic [25:0] jindex;

    assign opcode = D_Instr[31:26];
    assign rs     = D_Instr[25:21];
    assign rt     = D_Instr[20:16];
    assign imm16  = D_Instr[15:0];
    assign jindex = D_Instr[25:0];
    assign funct  = D_Instr[5:0];

    assign D_RD1 = select_operand(rs, grf[rs],
                                  E_fwd_we, E_fwd_A, E_fwd_D,
                                  M_fwd_we, M_fwd_A, M_fwd_D,
                                  W_we, W_A3, W_WD);
    assign D_RD2 = select_operand(rt, grf[rt],
                                  E_fwd_we, E_fwd_A, E_fwd_D,
                                  M_fwd_we, M_fwd_A, M_fwd_D,
                                  W_we, W_A3, W_WD);

    // ---------------- Instruction decode ----------------
    op_e op;

    always_comb begin
        // NOTE: default first so every path assigns op and no latch is inferred.
        op = OP_NOP;
        unique case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADDU: op = OP_ADDU;
                    FN_SUBU: op = OP_SUBU;
                    FN_JR:   op = OP_JR;
                    default: op = OP_NOP;
                endcase
            end
            OPC_ORI: op = OP_ORI;
            OPC_LUI: op = OP_LUI;
            OPC_LW:  op = OP_LW;
            OPC_SW:  op = OP_SW;
            OPC_BEQ: op = OP_BEQ;
            OPC_BNE: op = OP_BNE;
            OPC_J:   op = OP_J;
            OPC_JAL: op = OP_JAL;
            default: op = OP_NOP;
        endcase
    end

    // ---------------- Immediate extension ----------------
    logic [31:0] imm_sext;
    assign imm_sext = {{16{imm16[15]}}, imm16};

    always_comb begin
        D_Ext = imm_sext;
        case (op)
            OP_ORI:  D_Ext = {16'h0, imm16};
            OP_LUI:  D_Ext = {imm16, 16'h0};
            default: D_Ext = imm_sext;
        endcase
    end

    // ---------------- Next PC / control transfer ----------------
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        ops_equal;

    assign br_target = D_PC + 32'd4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {D_PC[31:28], jindex, 2'b00};
    assign ops_equal = (D_RD1 == D_RD2);

    always_comb begin
        NPC        = F_PC + 32'd4;
        D_br_taken = 1'b0;
        case (op)
            OP_BEQ: if (ops_equal) begin
                NPC        = br_target;
                D_br_taken = 1'b1;
            end
            OP_BNE: if (!ops_equal) begin
                NPC        = br_target;
                D_br_taken = 1'b1;
            end
            OP_J, OP_JAL: begin
                NPC        = j_target;
                D_br_taken = 1'b1;
            end
            OP_JR: begin
                NPC        = D_RD1;
                D_br_taken = 1'b1;
            end
            default: begin
                NPC        = F_PC + 32'd4;
                D_br_taken = 1'b0;
            end
        endcase
    end

endmodule
